// File: rtl/instr_loader_pkg.sv
// Shared definitions for the program loader: FSM encoding, HALT constant and
// word/byte geometry helpers.
package instr_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RECV  = 2'b01,
        ST_WRITE = 2'b10,
        ST_DONE  = 2'b11
    } loader_state_t;

    // Same value the MIPS control decode treats as HALT.
    localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

    localparam int DEFAULT_LEN    = 32;
    localparam int BYTES_PER_WORD = DEFAULT_LEN / 8;

    function automatic int bytes_per_word(input int len);
        return len / 8;
    endfunction

endpackage

// File: rtl/instr_loader_byte_assembler.sv
// Shifts received bytes into a LEN-bit word, first byte ending up as the MSB,
// and flags the cycle in which the last byte of a word is taken.
module instr_loader_byte_assembler
    import instr_loader_pkg::*;
#(
    parameter int LEN = 32
) (
    input  logic           i_clk,
    input  logic           i_clear,
    input  logic           i_valid,
    input  logic [7:0]     i_byte,
    output logic [LEN-1:0] o_word,
    output logic           o_word_ready
);

    localparam int BPW = bytes_per_word(LEN);
    localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [CW-1:0] LAST_BYTE = CW'(BPW - 1);

    logic [LEN-1:0] r_shift;
    logic [CW-1:0]  r_count;
    logic [LEN-1:0] w_next_shift;
    logic           w_last;

    assign w_next_shift = (r_shift << 8) | LEN'(i_byte);
    assign w_last       = (r_count == LAST_BYTE);

    always_ff @(posedge i_clk) begin
        if (i_clear) begin
            r_shift <= '0;
            r_count <= '0;
        end else if (i_valid) begin
            r_shift <= w_next_shift;
            r_count <= w_last ? '0 : r_count + 1'b1;
        end
    end

    // The completed word is presented combinationally so the parent can
    // register it on the same edge that samples the final byte.
    assign o_word       = w_next_shift;
    assign o_word_ready = i_valid && w_last;

endmodule

// File: rtl/instr_loader.sv
// Loads a program received byte-wise over UART into instruction memory,
// stopping on HALT or when memory is full.
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int              LEN            = 32,
    parameter int              CANT_MEM_INSTR = 64,
    parameter logic [LEN-1:0]  HALT_WORD      = LEN'(HALT_WORD_DEFAULT)
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic                              i_start,
    input  logic [7:0]                        i_rx_data,
    input  logic                              i_rx_done,
    output logic                              o_wr_en,
    output logic [$clog2(CANT_MEM_INSTR)-1:0] o_addr,
    output logic [LEN-1:0]                    o_data,
    output logic                              o_busy,
    output logic                              o_done,
    output logic                              o_overflow
);

    localparam int AW = $clog2(CANT_MEM_INSTR);
    localparam logic [AW-1:0] LAST_ADDR = AW'(CANT_MEM_INSTR - 1);

    loader_state_t  r_state;
    loader_state_t  w_next_state;
    logic [AW-1:0]  r_addr;
    logic [LEN-1:0] r_data;
    logic           r_busy;
    logic           r_overflow;

    logic           w_arm;
    logic           w_is_halt;
    logic           w_write_continue;
    logic           w_byte_accept;
    logic           w_clear;
    logic [LEN-1:0] w_word;
    logic           w_word_ready;

    assign w_arm            = i_start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_is_halt        = (r_data == HALT_WORD);
    assign w_write_continue = !w_is_halt && (r_addr != LAST_ADDR);
    // A byte during WRITE starts the next word unless loading ends here.
    assign w_byte_accept    = i_rx_done &&
                              ((r_state == ST_RECV) ||
                               ((r_state == ST_WRITE) && w_write_continue));
    assign w_clear          = i_rst || w_arm;

    instr_loader_byte_assembler #(
        .LEN (LEN)
    ) u_assembler (
        .i_clk        (i_clk),
        .i_clear      (w_clear),
        .i_valid      (w_byte_accept),
        .i_byte       (i_rx_data),
        .o_word       (w_word),
        .o_word_ready (w_word_ready)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (i_start) w_next_state = ST_RECV;
            ST_RECV:  if (w_word_ready) w_next_state = ST_WRITE;
            ST_WRITE: w_next_state = w_write_continue ? ST_RECV : ST_DONE;
            ST_DONE:  if (i_start) w_next_state = ST_RECV;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        o_wr_en = (r_state == ST_WRITE);
        o_done  = (r_state == ST_DONE);
    end

    // Address advances only after the full check, so it never wraps.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_addr     <= '0;
            r_data     <= '0;
            r_busy     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_busy <= (w_next_state == ST_RECV) || (w_next_state == ST_WRITE);
            if (w_arm) begin
                r_addr     <= '0;
                r_overflow <= 1'b0;
            end
            if ((r_state == ST_RECV) && w_word_ready) begin
                r_data <= w_word;
            end
            if (r_state == ST_WRITE) begin
                if (w_write_continue) begin
                    r_addr <= r_addr + 1'b1;
                end else if (!w_is_halt) begin
                    r_overflow <= 1'b1;
                end
            end
        end
    end

    assign o_addr     = r_addr;
    assign o_data     = r_data;
    assign o_busy     = r_busy;
    assign o_overflow = r_overflow;

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader with a 4-word memory: table of words plus
// hand-written sequences for back-to-back bytes, reset abort and start races.
module tb_instr_loader;
  localparam int LEN = 32;
  localparam int DEPTH = 4;
  localparam int AW = 2;

  logic           clk;
  logic           i_rst;
  logic           i_start;
  logic [7:0]     i_rx_data;
  logic           i_rx_done;
  logic           o_wr_en;
  logic [AW-1:0]  o_addr;
  logic [LEN-1:0] o_data;
  logic           o_busy;
  logic           o_done;
  logic           o_overflow;

  int checks = 0;
  int errors = 0;
  logic [AW+LEN-1:0] exp_q[$];
  logic prev_wr = 1'b0;

  instr_loader #(
    .LEN(LEN),
    .CANT_MEM_INSTR(DEPTH),
    .HALT_WORD(32'hFFFF_FFFF)
  ) dut (
    .i_clk(clk),
    .i_rst(i_rst),
    .i_start(i_start),
    .i_rx_data(i_rx_data),
    .i_rx_done(i_rx_done),
    .o_wr_en(o_wr_en),
    .o_addr(o_addr),
    .o_data(o_data),
    .o_busy(o_busy),
    .o_done(o_done),
    .o_overflow(o_overflow)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks: each is entered and left at a negedge
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    idle(2);
    i_rst = 1'b0;
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_rx_data = b;
    i_rx_done = 1'b1;
    @(negedge clk);
    i_rx_done = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit random_gaps);
    for (int k = 3; k >= 0; k--) begin
      if (random_gaps) idle($urandom_range(0, 2));
      send_byte(w[k*8 +: 8]);
    end
  endtask

  task automatic expect_write(input logic [AW-1:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wr_en"}, 64'(o_wr_en), 64'd0);
    check({tag, "_addr"}, 64'(o_addr), 64'd0);
    check({tag, "_data"}, 64'(o_data), 64'd0);
    check({tag, "_busy"}, 64'(o_busy), 64'd0);
    check({tag, "_done"}, 64'(o_done), 64'd0);
    check({tag, "_overflow"}, 64'(o_overflow), 64'd0);
  endtask

  // scoreboard: every write pulse pops one expected {addr, data}
  always @(negedge clk) begin
    if (o_wr_en === 1'b1) begin
      check("wr_en_spacing", 64'(prev_wr), 64'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", o_addr, o_data);
      end else begin
        check("write_addr_data", 64'({o_addr, o_data}), 64'(exp_q.pop_front()));
      end
    end
    prev_wr = (o_wr_en === 1'b1);
  end

  typedef struct {
    logic        restart;
    logic [31:0] word;
    logic        exp_wr;
    logic [1:0]  exp_wr_addr;
    logic [1:0]  exp_addr;
    logic        exp_done;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[9];

  initial begin
    i_rst = 1'b1;
    i_start = 1'b0;
    i_rx_data = 8'h00;
    i_rx_done = 1'b0;
    @(negedge clk);
    do_reset();
    check_all_zero("reset");

    // restart, word, write?, write addr, addr after, done, overflow
    vecs[0] = '{1'b1, 32'h2001_0005, 1'b1, 2'd0, 2'd1, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 32'h1122_3344, 1'b1, 2'd1, 2'd2, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 32'hFFFF_FFFF, 1'b1, 2'd2, 2'd2, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 32'h0102_0304, 1'b0, 2'd0, 2'd2, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 32'hAAAA_AAAA, 1'b1, 2'd0, 2'd1, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 32'h0000_0001, 1'b1, 2'd1, 2'd2, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 32'h8000_0000, 1'b1, 2'd2, 2'd3, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 32'h1234_5678, 1'b1, 2'd3, 2'd3, 1'b1, 1'b1};
    vecs[8] = '{1'b0, 32'hDEAD_BEEF, 1'b0, 2'd0, 2'd3, 1'b1, 1'b1};

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].restart) begin
        pulse_start();
        check($sformatf("v%0d_start_addr", i), 64'(o_addr), 64'd0);
        check($sformatf("v%0d_start_done", i), 64'(o_done), 64'd0);
        check($sformatf("v%0d_start_ovf", i), 64'(o_overflow), 64'd0);
      end
      if (vecs[i].exp_wr) expect_write(vecs[i].exp_wr_addr, vecs[i].word);
      send_word(vecs[i].word, 1'b1);
      idle(3);
      check($sformatf("v%0d_pending", i), 64'(exp_q.size()), 64'd0);
      check($sformatf("v%0d_addr", i), 64'(o_addr), 64'(vecs[i].exp_addr));
      check($sformatf("v%0d_done", i), 64'(o_done), 64'(vecs[i].exp_done));
      check($sformatf("v%0d_ovf", i), 64'(o_overflow), 64'(vecs[i].exp_ovf));
      check($sformatf("v%0d_busy", i), 64'(o_busy), 64'(!vecs[i].exp_done));
    end

    // byte strobe coincident with the WRITE pulse starts the next word
    do_reset();
    pulse_start();
    expect_write(2'd0, 32'hCAFE_0001);
    expect_write(2'd1, 32'h5A6B_7C8D);
    send_word(32'hCAFE_0001, 1'b0);
    send_word(32'h5A6B_7C8D, 1'b0);
    idle(3);
    check("b2b_pending", 64'(exp_q.size()), 64'd0);
    check("b2b_addr", 64'(o_addr), 64'd2);

    // bytes in IDLE are ignored, reset mid-word discards the partial word
    do_reset();
    send_word(32'h7777_7777, 1'b0);
    idle(3);
    check("idle_busy", 64'(o_busy), 64'd0);
    pulse_start();
    send_byte(8'hEE);
    send_byte(8'hDD);
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    check_all_zero("midreset");
    pulse_start();
    expect_write(2'd0, 32'h0123_4567);
    send_word(32'h0123_4567, 1'b1);
    idle(3);
    check("midreset_pending", 64'(exp_q.size()), 64'd0);
    check("midreset_addr", 64'(o_addr), 64'd1);

    // start and byte in the same IDLE cycle: the byte is dropped
    do_reset();
    i_start = 1'b1;
    i_rx_data = 8'h99;
    i_rx_done = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    i_rx_done = 1'b0;
    expect_write(2'd0, 32'h0BAD_F00D);
    send_word(32'h0BAD_F00D, 1'b1);
    idle(3);
    check("startrace_pending", 64'(exp_q.size()), 64'd0);
    check("startrace_addr", 64'(o_addr), 64'd1);

    idle(2);
    check("final_pending", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Receive-side counterpart of the debug data collector: it loads a program into instruction memory instead of reading state out.
- Takes bytes from the UART receiver and assembles them big-endian into LEN-bit instruction words.
- Writes each word to sequential instruction-memory addresses starting at 0.
- Stops on the HALT word or when memory is full, then signals done to the debug unit.

Parameters:
- LEN, 32, instruction/data word width; must be a multiple of 8.
- CANT_MEM_INSTR, 64, instruction memory depth in words; power of two, at least 2.
- HALT_WORD, 32'hFFFFFFFF, instruction value that ends loading.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  synchronous reset, active high.
- i_start  in  1  one-cycle pulse that arms the loader.
- i_rx_data  in  8  received byte; valid only while i_rx_done=1.
- i_rx_done  in  1  one-cycle strobe from the UART receiver.
- o_wr_en  out  1  instruction memory write enable, one-cycle pulse.
- o_addr  out  $clog2(CANT_MEM_INSTR)  write address.
- o_data  out  LEN  assembled instruction word.
- o_busy  out  1  high in RECV and WRITE.
- o_done  out  1  high in DONE, level.
- o_overflow  out  1  memory filled before HALT_WORD arrived, level.

Behaviour:
- Reset (synchronous, i_rst=1 at a clock edge):
  - Outputs: o_wr_en=0, o_addr=0, o_data=0, o_busy=0, o_done=0, o_overflow=0.
  - Internals: byte count=0, state=IDLE.
  - Reset mid-load aborts immediately; partial words are discarded.
- States: IDLE, RECV, WRITE, DONE; encodings live in the shared package.
- IDLE:
  - i_rx_done is ignored.
  - i_start moves to RECV and clears o_addr, the byte count and the shift register.
  - i_start and i_rx_done in the same cycle: start wins and that byte is dropped.
- RECV:
  - Each i_rx_done shifts the byte in: shift <= {shift[LEN-9:0], i_rx_data}. The first byte becomes the MSB.
  - The byte count increments modulo LEN/8.
  - On the (LEN/8)-th byte the full word is registered into o_data and the state moves to WRITE.
  - i_start is ignored.
- WRITE (exactly one cycle):
  - o_wr_en=1, o_addr = current word index, o_data = word.
  - Next state:
    - word == HALT_WORD → DONE with o_overflow=0. The HALT word itself is written.
    - else o_addr == CANT_MEM_INSTR-1 → DONE with o_overflow=1.
    - else → RECV, with o_addr incremented on the same edge.
  - An i_rx_done arriving during WRITE is accepted as byte 0 of the next word, so no byte is lost. If the next state is DONE, that byte is discarded.
- DONE:
  - o_done=1; bytes are ignored; o_addr holds the last written address.
  - i_start re-arms exactly as from IDLE and clears o_done and o_overflow.
- Latency: o_wr_en is asserted on the cycle after the edge that samples the last byte's i_rx_done.
- o_wr_en is never high in two consecutive cycles.
- o_addr never wraps: the full condition is checked before the increment.
- o_busy = (state==RECV) or (state==WRITE), registered.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE=2'b00, RECV=2'b01, WRITE=2'b10, DONE=2'b11);
  - the default HALT_WORD constant, shared with the MIPS control decode;
  - BYTES_PER_WORD = LEN/8.
- One natural sub-module: byte_assembler.
  - Contains the shift register plus the byte counter.
  - Outputs o_word and o_word_ready.
  - Has a clear input driven by start/reset.
- The top level keeps the FSM and address counter.

Test Plan:
1. Reset, i_start, then bytes 8'h20,8'h01,8'h00,8'h05 → one o_wr_en pulse with o_addr=0, o_data=32'h20010005 one cycle after the 4th strobe; state returns to RECV and o_addr becomes 1.
2. Two words followed by FF,FF,FF,FF → writes at addresses 0, 1 and 2; the address-2 write has o_data=32'hFFFFFFFF; then o_done=1, o_overflow=0. Further bytes produce no writes.
3. CANT_MEM_INSTR=4: five non-HALT words → writes at addresses 0–3, then o_done=1, o_overflow=1. The fifth word produces no write and o_addr stays 3.
4. A byte strobe in the same cycle as the WRITE pulse → it becomes the MSB of the next word; the next word is written correctly to the next address.
5. i_rst asserted after 2 bytes of a word → all outputs are 0 next cycle. i_start, then 4 new bytes → written at address 0 with only the new bytes.
6. i_start together with i_rx_done in IDLE → that byte is dropped. i_start in DONE → o_done and o_overflow clear and the next load starts at o_addr=0.
